// File: rtl/arb_rsp_router_if.sv
// Bus bundle between the arbitration tree, the router, the shared slave
// and the per-input response consumers.
//   req_*   : arbitrated request from the arbiter
//   slv_*   : request forwarded to the in-order slave
//   rsp_*   : in-order response coming back from the slave
//   route_* : per-input response fan-out (valid one-hot, data broadcast)
interface arb_rsp_router_if #(
    parameter int NumIn    = 4,
    parameter int ReqWidth = 32,
    parameter int RspWidth = 32,
    localparam int IdxWidth = $clog2(NumIn)
);
    logic                req_valid;
    logic                req_ready;
    logic [IdxWidth-1:0] req_idx;
    logic [ReqWidth-1:0] req_data;

    logic                slv_valid;
    logic                slv_ready;
    logic [ReqWidth-1:0] slv_data;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [RspWidth-1:0] rsp_data;

    logic [NumIn-1:0]    route_valid;
    logic [NumIn-1:0]    route_ready;
    logic [RspWidth-1:0] route_data;

    // Router side
    modport slave (
        input  req_valid, req_idx, req_data,
        output req_ready,
        output slv_valid, slv_data,
        input  slv_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        output route_valid, route_data,
        input  route_ready
    );

    // Environment side (arbiter, slave and input consumers)
    modport master (
        output req_valid, req_idx, req_data,
        input  req_ready,
        input  slv_valid, slv_data,
        output slv_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        input  route_valid, route_data,
        output route_ready
    );
endinterface

// File: rtl/arb_rsp_router.sv
// Forwards arbitrated requests to a shared in-order slave, remembers the
// winning input of each request in an order FIFO and steers each response
// back to the input that issued it. New requests are throttled once
// MaxTxns transactions are outstanding.
module arb_rsp_router #(
    parameter int NumIn    = 4,
    parameter int ReqWidth = 32,
    parameter int RspWidth = 32,
    parameter int MaxTxns  = 4,
    localparam int IdxWidth = $clog2(NumIn),
    localparam int CntWidth = $clog2(MaxTxns + 1),
    localparam int PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    arb_rsp_router_if.slave      bus,
    output logic [CntWidth-1:0]  outst_o,
    output logic                 err_o
);

    logic [IdxWidth-1:0] fifo_q [MaxTxns];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                err_q;

    logic                full, empty, push, pop;
    logic [IdxWidth-1:0] head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxTxns - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full  = (count_q == CntWidth'(MaxTxns));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // Request path: full gates both sides; slv_ready only feeds req_ready,
    // so there is no ready->valid loop towards the slave.
    assign bus.slv_valid = bus.req_valid & ~full;
    assign bus.req_ready = bus.slv_ready & ~full;
    assign bus.slv_data  = bus.req_data;
    assign push          = bus.req_valid & bus.req_ready;

    // Response path: accept only when something is outstanding and the
    // owning input is ready; data is broadcast to every input.
    assign bus.rsp_ready  = ~empty & bus.route_ready[head];
    assign bus.route_data = bus.rsp_data;
    assign pop            = bus.rsp_valid & bus.rsp_ready;

    // Steer response valid to the input recorded at the FIFO head
    always_comb begin
        bus.route_valid = '0;
        for (int i = 0; i < NumIn; i++) begin
            bus.route_valid[i] = bus.rsp_valid & ~empty & (head == IdxWidth'(i));
        end
    end

    // Order FIFO storage; contents are don't-care while count says empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.req_idx;
        end
    end

    // Pointers, occupancy and sticky error; reset beats flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
            // A response with nothing outstanding is never accepted; just flag it
            if (bus.rsp_valid && empty) err_q <= 1'b1;
        end
    end

    assign outst_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_arb_rsp_router.sv
// Directed bench for arb_rsp_router (NumIn=4, MaxTxns=4). Each table row is
// one clock cycle: inputs driven after the falling edge, outputs compared
// 1ns later, then the rising edge commits the row.
module tb_arb_rsp_router;
    localparam int NumIn = 4, ReqWidth = 32, RspWidth = 32, MaxTxns = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] outst;
    logic       err;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    arb_rsp_router_if #(.NumIn(NumIn), .ReqWidth(ReqWidth), .RspWidth(RspWidth)) bus ();

    arb_rsp_router #(
        .NumIn(NumIn), .ReqWidth(ReqWidth), .RspWidth(RspWidth), .MaxTxns(MaxTxns)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus),
        .outst_o (outst),
        .err_o   (err)
    );

    typedef struct {
        logic        rv;    // req_valid
        logic [1:0]  idx;   // req_idx
        logic        sr;    // slv_ready
        logic        pv;    // slave rsp_valid
        logic [3:0]  rr;    // per-input route_ready
        logic [31:0] pd;    // slave rsp_data
        logic        fl;    // flush
        logic        e_sv;  // expected slv_valid
        logic        e_rq;  // expected req_ready
        logic        e_pr;  // expected rsp_ready
        logic [3:0]  e_rt;  // expected route_valid
        logic [2:0]  e_cnt; // expected outst (state before this edge)
        logic        e_err; // expected err
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [1:0] idx, input logic sr, input logic pv,
                       input logic [3:0] rr, input logic [31:0] pd, input logic fl,
                       input logic e_sv, input logic e_rq, input logic e_pr,
                       input logic [3:0] e_rt, input logic [2:0] e_cnt, input logic e_err);
        vec_t v;
        v.rv = rv; v.idx = idx; v.sr = sr; v.pv = pv; v.rr = rr; v.pd = pd; v.fl = fl;
        v.e_sv = e_sv; v.e_rq = e_rq; v.e_pr = e_pr; v.e_rt = e_rt;
        v.e_cnt = e_cnt; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.req_valid   = v.rv;
        bus.req_idx     = v.idx;
        bus.req_data    = 32'hD000_0000 | {30'd0, v.idx};
        bus.slv_ready   = v.sr;
        bus.rsp_valid   = v.pv;
        bus.route_ready = v.rr;
        bus.rsp_data    = v.pd;
        flush           = v.fl;
    endtask

    initial begin
        // Idle / push-only / pop-only row shorthands built from add()
        // Slave not ready: nothing is pushed
        add(1, 2'd2, 0, 0, 4'h0, 0, 0,  1, 0, 0, 4'b0000, 3'd0, 0);
        add(0, 2'd0, 1, 0, 4'h0, 0, 0,  0, 1, 0, 4'b0000, 3'd0, 0);
        // Fill with 2,0,3,1 then the 5th request stalls
        add(1, 2'd2, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd0, 0);
        add(1, 2'd0, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd1, 0);
        add(1, 2'd3, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd2, 0);
        add(1, 2'd1, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd3, 0);
        add(1, 2'd2, 1, 0, 4'h0, 0, 0,  0, 0, 0, 4'b0000, 3'd4, 0);
        // In-order routing of A0..A3
        add(0, 2'd0, 1, 1, 4'hF, 32'hA0, 0,  0, 0, 1, 4'b0100, 3'd4, 0);
        add(0, 2'd0, 1, 1, 4'hF, 32'hA1, 0,  0, 1, 1, 4'b0001, 3'd3, 0);
        add(0, 2'd0, 1, 1, 4'hF, 32'hA2, 0,  0, 1, 1, 4'b1000, 3'd2, 0);
        add(0, 2'd0, 1, 1, 4'hF, 32'hA3, 0,  0, 1, 1, 4'b0010, 3'd1, 0);
        // Backpressure on input 1 for 3 cycles, then accepted
        add(1, 2'd1, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 2'd0, 1, 1, 4'b1101, 32'hB0, 0,  0, 1, 0, 4'b0010, 3'd1, 0);
        add(0, 2'd0, 1, 1, 4'b1111, 32'hB0, 0,  0, 1, 1, 4'b0010, 3'd1, 0);
        // Prime count=2 with 0,1, then push+pop for 10 cycles across the wrap
        add(1, 2'd0, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd0, 0);
        add(1, 2'd1, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd1, 0);
        for (int k = 0; k < 10; k++)
            add(1, 2'((k + 2) % 4), 1, 1, 4'hF, 32'hC0 + k, 0,
                1, 1, 1, 4'b0001 << (k % 4), 3'd2, 0);
        // FIFO now holds 2,3; add 0,1 to reach full
        add(1, 2'd0, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd2, 0);
        add(1, 2'd1, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd3, 0);
        // Full with push and pop together: push blocked, count 4->3
        add(1, 2'd3, 1, 1, 4'hF, 32'hE0, 0,  0, 0, 1, 4'b0100, 3'd4, 0);
        add(0, 2'd0, 1, 1, 4'hF, 32'hE1, 0,  0, 1, 1, 4'b1000, 3'd3, 0);
        add(0, 2'd0, 1, 1, 4'hF, 32'hE2, 0,  0, 1, 1, 4'b0001, 3'd2, 0);
        add(0, 2'd0, 1, 1, 4'hF, 32'hE3, 0,  0, 1, 1, 4'b0010, 3'd1, 0);
        // Response while empty: not accepted, error next cycle
        add(0, 2'd0, 1, 1, 4'hF, 32'hEE, 0,  0, 1, 0, 4'b0000, 3'd0, 0);
        add(1, 2'd3, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd0, 1);
        add(1, 2'd2, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd1, 1);
        add(1, 2'd1, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'b0000, 3'd2, 1);
        // Flush with 3 outstanding beats a concurrent push
        add(1, 2'd0, 1, 0, 4'h0, 0, 1,  1, 1, 0, 4'b0000, 3'd3, 1);
        add(0, 2'd0, 1, 0, 4'h0, 0, 0,  0, 1, 0, 4'b0000, 3'd0, 0);

        // Reset for 2 cycles with all inputs active
        bus.req_valid = 1; bus.req_idx = 2'd3; bus.req_data = 32'h1234;
        bus.slv_ready = 1; bus.rsp_valid = 1; bus.route_ready = 4'hF;
        bus.rsp_data = 32'h55; flush = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1; flush = 0;
        #1;
        chk("rst_outst", 32'(outst), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_route_valid", 32'(bus.route_valid), 0);
        chk("rst_rsp_ready", 32'(bus.rsp_ready), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        bus.req_valid = 0; bus.rsp_valid = 0;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n]);
            #1;
            chk($sformatf("v%0d_slv_valid", n), 32'(bus.slv_valid), 32'(vecs[n].e_sv));
            chk($sformatf("v%0d_req_ready", n), 32'(bus.req_ready), 32'(vecs[n].e_rq));
            chk($sformatf("v%0d_rsp_ready", n), 32'(bus.rsp_ready), 32'(vecs[n].e_pr));
            chk($sformatf("v%0d_route_valid", n), 32'(bus.route_valid), 32'(vecs[n].e_rt));
            chk($sformatf("v%0d_outst", n), 32'(outst), 32'(vecs[n].e_cnt));
            chk($sformatf("v%0d_err", n), 32'(err), 32'(vecs[n].e_err));
            chk($sformatf("v%0d_route_data", n), bus.route_data, vecs[n].pd);
            chk($sformatf("v%0d_slv_data", n), bus.slv_data,
                32'hD000_0000 | {30'd0, vecs[n].idx});
        end

        // Mid-run reset clears outstanding state and error
        @(negedge clk);
        bus.req_valid = 1; bus.req_idx = 2'd1; bus.rsp_valid = 1; bus.route_ready = 4'hF;
        @(negedge clk);
        bus.req_valid = 0;
        #1;
        chk("pre_rst_outst", 32'(outst), 1);
        @(negedge clk);
        bus.rsp_valid = 0;
        bus.req_valid = 1;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; bus.req_valid = 0;
        #1;
        chk("rst2_outst", 32'(outst), 0);
        chk("rst2_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
